// File: rtl/updown_counter_mod.sv
// Loadable up/down counter with an optional programmable wrap point.
// carry_out is an active-low ripple signal, so several stages can be chained into a wider counter.
module updown_counter_mod #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             preset_enable,
  input  logic [WIDTH-1:0] preset,
  input  logic             up_down,
  input  logic             carry_in,
  input  logic             mod_enable,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             wrapped
);

  logic [WIDTH-1:0] result_q, result_d;
  logic             wrapped_q, wrapped_d;

  logic [WIDTH-1:0] top;
  logic             at_top;
  logic             at_zero;
  logic             count_en;
  logic             terminal;

  // A preset above top counts as "at top", so the next up-count wraps straight to zero.
  assign top      = mod_enable ? modulus : {WIDTH{1'b1}};
  assign at_top   = (result_q >= top);
  assign at_zero  = (result_q == '0);
  assign count_en = ~carry_in;
  assign terminal = up_down ? at_top : at_zero;

  // Combinational, so the next stage sees its enable within the same cycle.
  assign carry_out = ~(count_en & terminal);

  always_comb begin
    // NOTE: give every always_comb output a default first, or the paths that skip an assignment infer a latch.
    result_d  = result_q;
    wrapped_d = 1'b0;
    if (preset_enable) begin
      result_d = preset;
    end else if (count_en) begin
      if (up_down) begin
        if (at_top) begin
          result_d  = '0;
          wrapped_d = 1'b1;
        end else begin
          result_d = result_q + 1'b1;
        end
      end else begin
        if (at_zero) begin
          result_d  = top;
          wrapped_d = 1'b1;
        end else begin
          result_d = result_q - 1'b1;
        end
      end
    end
  end

  // NOTE: use non-blocking assignments for state, so every flop samples the values from before the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      result_q  <= '0;
      wrapped_q <= 1'b0;
    end else begin
      result_q  <= result_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign result  = result_q;
  assign wrapped = wrapped_q;

endmodule

// File: tb/tb_updown_counter_mod.sv
// Self-checking bench for updown_counter_mod. It covers a single 4-bit counter against an arithmetic
// reference model, then two 4-bit stages cascaded into an 8-bit counter.
module tb_updown_counter_mod;

  localparam int W = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset, preset_enable, up_down, carry_in, mod_enable;
  logic [W-1:0] preset, modulus;
  logic [W-1:0] result;
  logic         carry_out, wrapped;

  updown_counter_mod #(.WIDTH(W)) u_dut (
    .clock(clock), .reset(reset), .preset_enable(preset_enable), .preset(preset),
    .up_down(up_down), .carry_in(carry_in), .mod_enable(mod_enable), .modulus(modulus),
    .result(result), .carry_out(carry_out), .wrapped(wrapped)
  );

  // Cascade: low stage carry_out drives high stage carry_in.
  logic         c_reset, c_pe, c_ci;
  logic [7:0]   c_preset;
  logic [W-1:0] lo_res, hi_res;
  logic         lo_co, hi_co, lo_wr, hi_wr;

  updown_counter_mod #(.WIDTH(W)) u_lo (
    .clock(clock), .reset(c_reset), .preset_enable(c_pe), .preset(c_preset[3:0]),
    .up_down(1'b1), .carry_in(c_ci), .mod_enable(1'b0), .modulus(4'd0),
    .result(lo_res), .carry_out(lo_co), .wrapped(lo_wr)
  );

  updown_counter_mod #(.WIDTH(W)) u_hi (
    .clock(clock), .reset(c_reset), .preset_enable(c_pe), .preset(c_preset[7:4]),
    .up_down(1'b1), .carry_in(lo_co), .mod_enable(1'b0), .modulus(4'd0),
    .result(hi_res), .carry_out(hi_co), .wrapped(hi_wr)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model state for the single counter.
  int m_res   = 0;
  bit m_wr    = 0;
  bit m_known = 0;

  function automatic int top_of();
    return mod_enable ? int'(modulus) : (1 << W) - 1;
  endfunction

  function automatic bit exp_co();
    if (carry_in) return 1'b1;
    if (up_down)  return !(m_res >= top_of());
    return !(m_res == 0);
  endfunction

  // Check carry_out against the current inputs, apply one edge, then check the registered outputs.
  task automatic tick(input string tag);
    int t;
    #1;
    if (m_known) check({tag, ".carry_out"}, {31'b0, carry_out}, {31'b0, exp_co()});
    t = top_of();
    if (reset) begin
      m_res = 0; m_wr = 0; m_known = 1;
    end else if (preset_enable) begin
      m_res = int'(preset); m_wr = 0;
    end else if (!carry_in) begin
      if (up_down) begin
        if (m_res >= t) begin m_res = 0; m_wr = 1; end
        else begin m_res = m_res + 1; m_wr = 0; end
      end else begin
        if (m_res == 0) begin m_res = t; m_wr = 1; end
        else begin m_res = m_res - 1; m_wr = 0; end
      end
    end else begin
      m_wr = 0;
    end
    @(posedge clock);
    #1;
    if (m_known) begin
      check({tag, ".result"},  {28'b0, result},  m_res[31:0]);
      check({tag, ".wrapped"}, {31'b0, wrapped}, {31'b0, m_wr});
    end
  endtask

  task automatic set_in(input bit rst, input bit pe, input int pv, input bit ud,
                        input bit ci, input bit me, input int md);
    reset = rst; preset_enable = pe; preset = pv[W-1:0];
    up_down = ud; carry_in = ci; mod_enable = me; modulus = md[W-1:0];
  endtask

  // 8-bit cascade model.
  int c_model = 0;

  task automatic ctick(input string tag);
    bit e_lo, e_hi;
    #1;
    e_lo = 0; e_hi = 0;
    if (c_reset) c_model = 0;
    else if (c_pe) c_model = int'(c_preset);
    else if (!c_ci) begin
      e_lo = (c_model % 16) == 15;
      e_hi = (c_model == 255);
      c_model = (c_model + 1) % 256;
    end
    @(posedge clock);
    #1;
    check({tag, ".count"},  {24'b0, hi_res, lo_res}, c_model[31:0]);
    check({tag, ".lo_wrap"}, {31'b0, lo_wr}, {31'b0, e_lo});
    check({tag, ".hi_wrap"}, {31'b0, hi_wr}, {31'b0, e_hi});
  endtask

  initial begin
    c_reset = 1; c_pe = 0; c_ci = 1; c_preset = '0;
    set_in(1, 0, 0, 1, 1, 0, 0);

    // Reset state: result 0, carry_out 1 with counting disabled.
    tick("reset");
    set_in(0, 0, 0, 1, 1, 0, 0);
    #1 check("reset.carry_out", {31'b0, carry_out}, 32'd1);

    // Natural up-count through all 16 values.
    set_in(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) tick("nat_up");

    // Modulus 5: sequence 0..5 then 0.
    set_in(0, 1, 0, 1, 1, 1, 5); tick("mod_load");
    set_in(0, 0, 0, 1, 0, 1, 5);
    for (int i = 0; i < 7; i++) tick("mod5_up");

    // Preset above top, then count up wraps to 0 immediately.
    set_in(0, 1, 9, 1, 0, 1, 5); tick("pre9");
    set_in(0, 0, 0, 1, 0, 1, 5); tick("pre9_up");
    // Preset above top, then count down walks to 0 and reloads top.
    set_in(0, 1, 9, 0, 0, 1, 5); tick("pre9b");
    set_in(0, 0, 0, 0, 0, 1, 5);
    for (int i = 0; i < 11; i++) tick("pre9_down");

    // Reset beats preset on the same edge.
    set_in(0, 1, 6, 1, 0, 0, 0); tick("load6");
    set_in(0, 0, 0, 1, 0, 0, 0); tick("to7");
    set_in(1, 1, 3, 1, 0, 0, 0); tick("rst_vs_pre");
    set_in(0, 1, 3, 1, 0, 0, 0); tick("pre3");

    // Hold keeps the value and never pulses wrapped.
    set_in(0, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) tick("hold");

    // Modulus 0: stuck at 0, wrapping on every edge in both directions.
    set_in(0, 0, 0, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) tick("mod0_up");
    set_in(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) tick("mod0_dn");

    // Natural down-count from 0 wraps to all-ones.
    set_in(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick("nat_dn");

    // Randomized stimulus against the model.
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 15),
             $urandom_range(0, 1), $urandom_range(0, 3) == 0, $urandom_range(0, 1),
             ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 15));
      tick("rand");
    end

    // Cascade: 0x0F -> 0x10 in one edge, 0xFF -> 0x00 with both stages wrapping.
    set_in(0, 0, 0, 1, 1, 0, 0);
    c_reset = 1; c_pe = 0; c_ci = 1; ctick("c_reset");
    c_reset = 0; c_pe = 1; c_preset = 8'h0F; ctick("c_load0f");
    c_pe = 0; c_ci = 0; ctick("c_0f_10");
    c_pe = 1; c_preset = 8'hFF; ctick("c_loadff");
    c_pe = 0; c_ci = 0; ctick("c_ff_00");
    c_pe = 1; c_preset = 8'($urandom_range(0, 255)); ctick("c_loadr");
    c_pe = 0;
    for (int i = 0; i < 300; i++) begin
      c_ci = ($urandom_range(0, 5) == 0);
      ctick("c_rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
